cp0_reg_file: RTL and testbench

Coprocessor-0 register file in the MEM/WB region, downstream of the ID-stage CP0 decode. It consumes the decoded CP0 write enable, read enable, write data and 8-bit address ({rd, sel}), and holds BadVAddr, Count, Compare, Status, Cause and EPC. It records exceptions and ERET from the commit point, runs the Count/Compare timer, and raises the interrupt request to the exception unit.

---
 rtl/cp0_reg_file_pkg.sv | 44 ++++
 rtl/cp0_reg_file_timer.sv | 61 ++++++
 rtl/cp0_reg_file.sv | 148 ++++++++++++++
 tb/tb_cp0_reg_file.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_reg_file_pkg.sv
// rtl/cp0_reg_file_pkg.sv - CP0 addresses, Status/Cause field positions, ExcCodes, reset values
package cp0_reg_file_pkg;

  localparam int DATA_BUS     = 32;
  localparam int CP0_ADDR_BUS = 8;

  localparam logic [7:0] CP0_BADVADDR = 8'h40;
  localparam logic [7:0] CP0_COUNT    = 8'h48;
  localparam logic [7:0] CP0_COMPARE  = 8'h58;
  localparam logic [7:0] CP0_STATUS   = 8'h60;
  localparam logic [7:0] CP0_CAUSE    = 8'h68;
  localparam logic [7:0] CP0_EPC      = 8'h70;

  localparam int STATUS_IE    = 0;
  localparam int STATUS_EXL   = 1;
  localparam int STATUS_IM_LO = 8;
  localparam int STATUS_IM_HI = 15;
  localparam int STATUS_BEV   = 22;

  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_EXC_HI = 6;
  localparam int CAUSE_IP_LO  = 8;
  localparam int CAUSE_IP_HI  = 15;
  localparam int CAUSE_TI     = 30;
  localparam int CAUSE_BD     = 31;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_SYS  = 5'd8,
    EXC_BP   = 5'd9,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  localparam logic [31:0] STATUS_RESET_VAL = 32'h0040_0000;

  // Only address-error exceptions capture the faulting address into BadVAddr.
  function automatic logic is_addr_exc(input logic [4:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/cp0_reg_file_timer.sv
// rtl/cp0_reg_file_timer.sv - Count/Compare timer with divider and TI flag
// Entire module exists only when CP0_TIMER_EN is defined.
`ifdef CP0_TIMER_EN
module cp0_reg_file_timer
  import cp0_reg_file_pkg::*;
#(
  parameter int COUNT_DIV = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_count_we,
  input  logic                i_compare_we,
  input  logic [DATA_BUS-1:0] i_wdata,
  output logic [DATA_BUS-1:0] o_count,
  output logic [DATA_BUS-1:0] o_compare,
  output logic                o_ti
);
  localparam logic DIV_LAST = 1'(COUNT_DIV - 1);

  logic                r_div;
  logic [DATA_BUS-1:0] r_count;
  logic [DATA_BUS-1:0] r_compare;
  logic                r_ti;
  logic                w_tick;
  logic [DATA_BUS-1:0] w_count_inc;

  assign w_tick      = (r_div == DIV_LAST);
  assign w_count_inc = r_count + 32'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div     <= 1'b0;
      r_count   <= '0;
      r_compare <= '0;
      r_ti      <= 1'b0;
    end else begin
      if (i_count_we) begin
        r_count <= i_wdata;
        r_div   <= 1'b0;
      end else if (w_tick) begin
        r_count <= w_count_inc;
        r_div   <= 1'b0;
      end else begin
        r_div <= r_div + 1'b1;
      end
      // A Compare write overrides a match on the same edge; loading Count never matches.
      if (i_compare_we) begin
        r_compare <= i_wdata;
        r_ti      <= 1'b0;
      end else if (!i_count_we && w_tick && (w_count_inc == r_compare)) begin
        r_ti <= 1'b1;
      end
    end
  end

  assign o_count   = r_count;
  assign o_compare = r_compare;
  assign o_ti      = r_ti;

endmodule
`endif

// File: rtl/cp0_reg_file.sv
// rtl/cp0_reg_file.sv - CP0 register file: BadVAddr, Status, Cause, EPC, exception/ERET commit, int_req
// Count/Compare timer is built only when CP0_TIMER_EN is defined.
module cp0_reg_file
  import cp0_reg_file_pkg::*;
#(
  parameter int          COUNT_DIV    = 2,
  parameter logic [31:0] STATUS_RESET = STATUS_RESET_VAL
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cp0_write_en,
  input  logic                    cp0_read_en,
  input  logic [CP0_ADDR_BUS-1:0] cp0_addr,
  input  logic [DATA_BUS-1:0]     cp0_write_data,
  output logic [DATA_BUS-1:0]     cp0_read_data,
  input  logic [5:0]              int_i,
  input  logic                    exc_valid,
  input  logic [4:0]              exc_code,
  input  logic [DATA_BUS-1:0]     exc_pc,
  input  logic [DATA_BUS-1:0]     exc_badvaddr,
  input  logic                    exc_in_delay_slot,
  input  logic                    eret,
  output logic [DATA_BUS-1:0]     status_o,
  output logic [DATA_BUS-1:0]     cause_o,
  output logic [DATA_BUS-1:0]     epc_o,
  output logic                    int_req
);
  logic [DATA_BUS-1:0] r_badvaddr;
  logic [DATA_BUS-1:0] r_epc;
  logic [7:0]          r_im;
  logic                r_exl;
  logic                r_ie;
  logic                r_bd;
  logic [4:0]          r_exc_code;
  logic [5:0]          r_ip_hw;
  logic [1:0]          r_ip_sw;

  logic                w_mtc0;
  logic                w_ti;
  logic [DATA_BUS-1:0] w_status;
  logic [DATA_BUS-1:0] w_cause;
  logic [DATA_BUS-1:0] w_read_data;

  // A committing exception drops any MTC0 in the same cycle.
  assign w_mtc0 = cp0_write_en & ~exc_valid;

`ifdef CP0_TIMER_EN
  logic                w_count_we;
  logic                w_compare_we;
  logic [DATA_BUS-1:0] w_count;
  logic [DATA_BUS-1:0] w_compare;

  assign w_count_we   = w_mtc0 & (cp0_addr == CP0_COUNT);
  assign w_compare_we = w_mtc0 & (cp0_addr == CP0_COMPARE);

  cp0_reg_file_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_count_we  (w_count_we),
    .i_compare_we(w_compare_we),
    .i_wdata     (cp0_write_data),
    .o_count     (w_count),
    .o_compare   (w_compare),
    .o_ti        (w_ti)
  );
`else
  assign w_ti = 1'b0;
`endif

  if ((COUNT_DIV != 1) && (COUNT_DIV != 2)) begin : g_illegal_count_div
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_badvaddr <= '0;
      r_epc      <= '0;
      r_im       <= STATUS_RESET[STATUS_IM_HI:STATUS_IM_LO];
      r_exl      <= STATUS_RESET[STATUS_EXL];
      r_ie       <= STATUS_RESET[STATUS_IE];
      r_bd       <= 1'b0;
      r_exc_code <= '0;
      r_ip_hw    <= '0;
      r_ip_sw    <= '0;
    end else begin
      r_ip_hw <= {int_i[5] | w_ti, int_i[4:0]};
      if (exc_valid) begin
        if (!r_exl) begin
          r_epc <= exc_in_delay_slot ? (exc_pc - 32'd4) : exc_pc;
          r_bd  <= exc_in_delay_slot;
        end
        r_exc_code <= exc_code;
        r_exl      <= 1'b1;
        if (is_addr_exc(exc_code)) r_badvaddr <= exc_badvaddr;
      end else if (eret) begin
        r_exl <= 1'b0;
      end
      if (w_mtc0) begin
        case (cp0_addr)
          CP0_STATUS: begin
            r_im  <= cp0_write_data[STATUS_IM_HI:STATUS_IM_LO];
            r_exl <= cp0_write_data[STATUS_EXL];
            r_ie  <= cp0_write_data[STATUS_IE];
          end
          CP0_CAUSE: r_ip_sw <= cp0_write_data[9:8];
          CP0_EPC:   r_epc   <= cp0_write_data;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    w_status                            = '0;
    w_status[STATUS_BEV]                = 1'b1;
    w_status[STATUS_IM_HI:STATUS_IM_LO] = r_im;
    w_status[STATUS_EXL]                = r_exl;
    w_status[STATUS_IE]                 = r_ie;
    w_cause                             = '0;
    w_cause[CAUSE_BD]                   = r_bd;
    w_cause[CAUSE_TI]                   = w_ti;
    w_cause[CAUSE_IP_HI:CAUSE_IP_LO]    = {r_ip_hw, r_ip_sw};
    w_cause[CAUSE_EXC_HI:CAUSE_EXC_LO]  = r_exc_code;
  end

  always_comb begin
    w_read_data = '0;
    if (cp0_read_en) begin
      case (cp0_addr)
        CP0_BADVADDR: w_read_data = r_badvaddr;
`ifdef CP0_TIMER_EN
        CP0_COUNT:    w_read_data = w_count;
        CP0_COMPARE:  w_read_data = w_compare;
`endif
        CP0_STATUS:   w_read_data = w_status;
        CP0_CAUSE:    w_read_data = w_cause;
        CP0_EPC:      w_read_data = r_epc;
        default:      w_read_data = '0;
      endcase
    end
  end

  assign cp0_read_data = w_read_data;
  assign status_o      = w_status;
  assign cause_o       = w_cause;
  assign epc_o         = r_epc;
  assign int_req       = r_ie & ~r_exl & (|({r_ip_hw, r_ip_sw} & r_im));

endmodule

// File: tb/tb_cp0_reg_file.sv
// tb/tb_cp0_reg_file.sv - self-checking bench for cp0_reg_file against a behavioural model
module tb_cp0_reg_file;
  localparam int TB_COUNT_DIV = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cp0_write_en;
  logic        cp0_read_en;
  logic [7:0]  cp0_addr;
  logic [31:0] cp0_write_data;
  logic [31:0] cp0_read_data;
  logic [5:0]  int_i;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic [31:0] exc_badvaddr;
  logic        exc_in_delay_slot;
  logic        eret;
  logic [31:0] status_o;
  logic [31:0] cause_o;
  logic [31:0] epc_o;
  logic        int_req;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  logic [31:0] m_status, m_cause, m_epc, m_badv;
`ifdef CP0_TIMER_EN
  logic [31:0] m_count, m_compare;
  int          m_phase;
`endif

  cp0_reg_file #(.COUNT_DIV(TB_COUNT_DIV), .STATUS_RESET(32'h0040_0000)) dut (
    .clk(clk), .rst_n(rst_n), .cp0_write_en(cp0_write_en), .cp0_read_en(cp0_read_en),
    .cp0_addr(cp0_addr), .cp0_write_data(cp0_write_data), .cp0_read_data(cp0_read_data),
    .int_i(int_i), .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc),
    .exc_badvaddr(exc_badvaddr), .exc_in_delay_slot(exc_in_delay_slot), .eret(eret),
    .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o), .int_req(int_req)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_status = 32'h0040_0000;
    m_cause  = 32'h0;
    m_epc    = 32'h0;
    m_badv   = 32'h0;
`ifdef CP0_TIMER_EN
    m_count   = 32'h0;
    m_compare = 32'h0;
    m_phase   = 0;
`endif
  endtask

  function automatic logic [31:0] exp_read();
    if (!cp0_read_en) return 32'h0;
    if (cp0_addr == 8'h40) return m_badv;
`ifdef CP0_TIMER_EN
    if (cp0_addr == 8'h48) return m_count;
    if (cp0_addr == 8'h58) return m_compare;
`endif
    if (cp0_addr == 8'h60) return m_status;
    if (cp0_addr == 8'h68) return m_cause;
    if (cp0_addr == 8'h70) return m_epc;
    return 32'h0;
  endfunction

  function automatic logic exp_int_req();
    return m_status[0] && !m_status[1] && ((m_cause[15:8] & m_status[15:8]) != 8'h0);
  endfunction

  // Applies one clock edge's worth of architectural effects to the model.
  task automatic model_step();
    logic old_exl, old_ti;
`ifdef CP0_TIMER_EN
    logic count_w, compare_w;
`endif
    if (!rst_n) begin
      model_reset();
      return;
    end
    old_exl = m_status[1];
    old_ti  = m_cause[30];
    if (exc_valid) begin
      if (!old_exl) begin
        m_epc       = exc_in_delay_slot ? exc_pc - 32'd4 : exc_pc;
        m_cause[31] = exc_in_delay_slot;
      end
      m_cause[6:2] = exc_code;
      m_status[1]  = 1'b1;
      if (exc_code == 5'd4 || exc_code == 5'd5) m_badv = exc_badvaddr;
    end else begin
      if (eret) m_status[1] = 1'b0;
      if (cp0_write_en) begin
        if (cp0_addr == 8'h60) m_status = (m_status & ~32'h0000_FF03) | (cp0_write_data & 32'h0000_FF03);
        if (cp0_addr == 8'h68) m_cause = (m_cause & ~32'h0000_0300) | (cp0_write_data & 32'h0000_0300);
        if (cp0_addr == 8'h70) m_epc = cp0_write_data;
      end
    end
`ifdef CP0_TIMER_EN
    count_w   = cp0_write_en && !exc_valid && cp0_addr == 8'h48;
    compare_w = cp0_write_en && !exc_valid && cp0_addr == 8'h58;
    if (count_w) begin
      m_count = cp0_write_data;
      m_phase = 0;
    end else begin
      m_phase++;
      if (m_phase == TB_COUNT_DIV) begin
        m_phase = 0;
        m_count = m_count + 32'd1;
        if (m_count == m_compare && !compare_w) m_cause[30] = 1'b1;
      end
    end
    if (compare_w) begin
      m_compare   = cp0_write_data;
      m_cause[30] = 1'b0;
    end
`endif
    m_cause[15:10] = {int_i[5] | old_ti, int_i[4:0]};
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("status_o", status_o, m_status);
      check("cause_o", cause_o, m_cause);
      check("epc_o", epc_o, m_epc);
      check("int_req", {31'b0, int_req}, {31'b0, exp_int_req()});
      check("cp0_read_data", cp0_read_data, exp_read());
    end
  end

  task automatic idle();
    cp0_write_en = 0; cp0_read_en = 0; cp0_addr = 0; cp0_write_data = 0;
    int_i = 0; exc_valid = 0; exc_code = 0; exc_pc = 0; exc_badvaddr = 0;
    exc_in_delay_slot = 0; eret = 0;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic mtc0(input logic [7:0] a, input logic [31:0] d);
    idle();
    cp0_write_en = 1; cp0_addr = a; cp0_write_data = d;
    step();
    idle();
  endtask

  task automatic mfc0_check(input string name, input logic [7:0] a, input logic [31:0] exp);
    idle();
    cp0_read_en = 1; cp0_addr = a;
    #1;
    check(name, cp0_read_data, exp);
  endtask

  logic [4:0] codes [7] = '{5'd0, 5'd4, 5'd5, 5'd8, 5'd9, 5'd10, 5'd12};
  logic [7:0] addrs [6] = '{8'h40, 8'h48, 8'h58, 8'h60, 8'h68, 8'h70};

  initial begin
    rst_n = 0;
    idle();
    model_reset();
    chk_en = 1;
    step();
    step();
    check("reset_status", status_o, 32'h0040_0000);
    check("reset_cause", cause_o, 32'h0);
    check("reset_epc", epc_o, 32'h0);
    check("reset_int_req", {31'b0, int_req}, 32'h0);
    rst_n = 1;
    step();

    mtc0(8'h60, 32'hFFFF_FFFF);
    mfc0_check("status_mask", 8'h60, 32'h0040_FF03);
    mtc0(8'h40, 32'h0000_1234);
    mfc0_check("badvaddr_readonly", 8'h40, 32'h0);
    mtc0(8'h80, 32'h5555_5555);
    mfc0_check("unimpl_read", 8'h80, 32'h0);

`ifdef CP0_TIMER_EN
    mtc0(8'h60, 32'h0040_8001);
    mtc0(8'h58, 32'd10);
    mtc0(8'h48, 32'd0);
    repeat (19) step();
    check("ti_before_match", {31'b0, cause_o[30]}, 32'h0);
    step();
    check("ti_at_match", {31'b0, cause_o[30]}, 32'h1);
    check("int_req_lag", {31'b0, int_req}, 32'h0);
    step();
    check("int_req_timer", {31'b0, int_req}, 32'h1);
    mtc0(8'h58, 32'd1000);
    check("ti_cleared", {31'b0, cause_o[30]}, 32'h0);
`else
    mtc0(8'h48, 32'd5);
    mfc0_check("count_absent", 8'h48, 32'h0);
    mtc0(8'h58, 32'd5);
    mfc0_check("compare_absent", 8'h58, 32'h0);
`endif

    mtc0(8'h60, 32'h0040_8001);
    int_i = 6'b100000;
    step();
    check("ip7_from_int5", {31'b0, cause_o[15]}, 32'h1);
    check("int_req_hw", {31'b0, int_req}, 32'h1);
    idle();
    step();

    exc_valid = 1; exc_code = 5'd4; exc_pc = 32'hBFC0_0104;
    exc_in_delay_slot = 1; exc_badvaddr = 32'h3;
    step();
    idle();
    check("exc_epc", epc_o, 32'hBFC0_0100);
    check("exc_bd", {31'b0, cause_o[31]}, 32'h1);
    check("exc_code", {27'b0, cause_o[6:2]}, 32'd4);
    check("exc_exl", {31'b0, status_o[1]}, 32'h1);
    mfc0_check("exc_badvaddr", 8'h40, 32'h3);

    idle();
    exc_valid = 1; exc_code = 5'd8; exc_pc = 32'h8000_0200;
    step();
    idle();
    check("nested_epc", epc_o, 32'hBFC0_0100);
    check("nested_code", {27'b0, cause_o[6:2]}, 32'd8);
    eret = 1;
    step();
    idle();
    check("eret_exl", {31'b0, status_o[1]}, 32'h0);

    exc_valid = 1; exc_code = 5'd12; exc_pc = 32'h8000_0300; eret = 1;
    cp0_write_en = 1; cp0_addr = 8'h70; cp0_write_data = 32'h0000_DEAD;
    step();
    idle();
    check("simul_exl", {31'b0, status_o[1]}, 32'h1);
    check("simul_epc", epc_o, 32'h8000_0300);
    eret = 1;
    step();
    idle();

    repeat (3000) begin
      idle();
      int_i = 6'($urandom);
      cp0_read_en = 1'($urandom);
      cp0_addr = ($urandom_range(0, 7) < 6) ? addrs[$urandom_range(0, 5)] : 8'($urandom);
      cp0_write_en = ($urandom_range(0, 9) < 3);
      cp0_write_data = $urandom;
`ifdef CP0_TIMER_EN
      if (cp0_addr == 8'h48 && $urandom_range(0, 1) == 1)
        cp0_write_data = m_compare - 32'($urandom_range(0, 8));
      if (cp0_addr == 8'h48 && $urandom_range(0, 15) == 0)
        cp0_write_data = 32'hFFFF_FFFC;
`endif
      exc_valid = ($urandom_range(0, 19) == 0);
      exc_code = ($urandom_range(0, 3) == 0) ? 5'($urandom) : codes[$urandom_range(0, 6)];
      exc_pc = $urandom;
      exc_badvaddr = $urandom;
      exc_in_delay_slot = 1'($urandom);
      eret = ($urandom_range(0, 19) == 0);
      if (eret) cp0_write_en = 0;
      step();
    end

    mtc0(8'h60, 32'h0000_FF01);
    check("pre_reset_status", status_o, 32'h0040_FF01);
    rst_n = 0;
    model_reset();
    #1;
    check("midrun_reset_status", status_o, 32'h0040_0000);
    check("midrun_reset_epc", epc_o, 32'h0);
    check("midrun_reset_int_req", {31'b0, int_req}, 32'h0);
    step();
    rst_n = 1;
    step();
    step();

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
